// File: rtl/mux_channel_scanner_if.sv
// Bus between the channel scanner, its controller and the 4:1 byte multiplexer.
// The master side drives scan control and the mux output; the slave side is the scanner.
interface mux_channel_scanner_if #(
    parameter int DWELL_W = 16
);
    logic               start;
    logic               stop;
    logic               mode;
    logic [3:0]         enable_mask;
    logic [DWELL_W-1:0] dwell;
    logic [7:0]         y;
    logic [1:0]         s;
    logic [7:0]         sample;
    logic [1:0]         sample_ch;
    logic               sample_valid;
    logic               busy;
    logic               done;

    modport master (
        output start, stop, mode, enable_mask, dwell, y,
        input  s, sample, sample_ch, sample_valid, busy, done
    );

    modport slave (
        input  start, stop, mode, enable_mask, dwell, y,
        output s, sample, sample_ch, sample_valid, busy, done
    );
endinterface

// File: rtl/mux_channel_scanner.sv
// Sequencer for a 4:1 byte mux: steps the select over enabled channels, dwells so the
// selected input settles, then captures the byte with its channel and a valid strobe.
module mux_channel_scanner #(
    parameter int DWELL_W = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    mux_channel_scanner_if.slave  bus
);

    typedef enum logic {IDLE, DWELL} state_t;

    state_t             state_q, state_d;
    logic [3:0]         mask_q, mask_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d;
    logic [1:0]         s_q, s_d;
    logic [7:0]         sample_q, sample_d;
    logic [1:0]         sample_ch_q, sample_ch_d;
    logic               valid_q, valid_d;
    logic               done_q, done_d;

    function automatic logic [1:0] lowest_ch(input logic [3:0] m);
        lowest_ch = 2'd0;
        for (int i = 3; i >= 0; i--) if (m[i]) lowest_ch = 2'(i);
    endfunction

    function automatic logic [1:0] highest_ch(input logic [3:0] m);
        highest_ch = 2'd0;
        for (int i = 0; i <= 3; i++) if (m[i]) highest_ch = 2'(i);
    endfunction

    // Next enabled channel above cur, wrapping; the smallest step wins.
    function automatic logic [1:0] next_ch(input logic [3:0] m, input logic [1:0] cur);
        logic [1:0] c;
        next_ch = cur;
        for (int k = 3; k >= 1; k--) begin
            c = cur + 2'(k);
            if (m[c]) next_ch = c;
        end
    endfunction

    function automatic logic [DWELL_W-1:0] eff_dwell(input logic [DWELL_W-1:0] d);
        eff_dwell = (d == '0) ? DWELL_W'(1) : d;
    endfunction

    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latches).
    always_comb begin
        state_d     = state_q;
        mask_d      = mask_q;
        dwell_d     = dwell_q;
        cnt_d       = cnt_q;
        s_d         = s_q;
        sample_d    = sample_q;
        sample_ch_d = sample_ch_q;
        valid_d     = 1'b0;
        done_d      = 1'b0;

        if (bus.stop) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.start && (bus.enable_mask != 4'd0)) begin
                        state_d = DWELL;
                        mask_d  = bus.enable_mask;
                        dwell_d = eff_dwell(bus.dwell);
                        cnt_d   = eff_dwell(bus.dwell);
                        s_d     = lowest_ch(bus.enable_mask);
                    end
                end
                DWELL: begin
                    if (cnt_q == DWELL_W'(1)) begin
                        sample_d    = bus.y;
                        sample_ch_d = s_q;
                        valid_d     = 1'b1;
                        cnt_d       = dwell_q;
                        if (s_q == highest_ch(mask_q)) begin
                            if (!bus.mode) begin
                                state_d = IDLE;
                                done_d  = 1'b1;
                            end else if (bus.enable_mask == 4'd0) begin
                                // Continuous scan with the mask cleared ends quietly.
                                state_d = IDLE;
                            end else begin
                                mask_d  = bus.enable_mask;
                                dwell_d = eff_dwell(bus.dwell);
                                cnt_d   = eff_dwell(bus.dwell);
                                s_d     = lowest_ch(bus.enable_mask);
                            end
                        end else begin
                            s_d = next_ch(mask_q, s_q);
                        end
                    end else begin
                        cnt_d = cnt_q - DWELL_W'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            mask_q      <= 4'd0;
            dwell_q     <= '0;
            cnt_q       <= '0;
            s_q         <= 2'd0;
            sample_q    <= 8'd0;
            sample_ch_q <= 2'd0;
            valid_q     <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            mask_q      <= mask_d;
            dwell_q     <= dwell_d;
            cnt_q       <= cnt_d;
            s_q         <= s_d;
            sample_q    <= sample_d;
            sample_ch_q <= sample_ch_d;
            valid_q     <= valid_d;
            done_q      <= done_d;
        end
    end

    assign bus.s            = s_q;
    assign bus.sample       = sample_q;
    assign bus.sample_ch    = sample_ch_q;
    assign bus.sample_valid = valid_q;
    assign bus.busy         = (state_q != IDLE);
    assign bus.done         = done_q;

endmodule
